// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice game controller.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROLL_A,
        WAIT_B,
        ROLL_B,
        JUDGE,
        SHOW
    } state_t;

    localparam logic [2:0] WIN_NONE = 3'd0;
    localparam logic [2:0] WIN_A    = 3'd1;
    localparam logic [2:0] WIN_B    = 3'd2;
    localparam logic [2:0] WIN_DRAW = 3'd3;

    localparam logic [2:0] DIE_MIN  = 3'd1;
    localparam logic [2:0] DIE_MAX  = 3'd6;

endpackage

// File: rtl/dice_counter.sv
// One player's die: steps 1..6 and wraps while enabled, otherwise holds.
module dice_counter
    import dice_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= DIE_MIN;
        else if (en)
            value <= (value == DIE_MAX) ? DIE_MIN : value + 3'd1;
    end

endmodule

// File: rtl/dice_judge.sv
// Dice game controller: A rolls, then B, result code held on win for HOLD_CYCLES.
// Build option: define DICE_TIE_REROLL_EN to drop ties straight back to idle with no code.
module dice_judge
    import dice_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000,
    parameter int HW          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_a,
    input  logic       roll_b,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic [2:0] win,
    output logic       busy
);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state, next_state;
    logic [2:0]    win_next;
    logic [HW-1:0] hold_cnt, cnt_next;
    logic          en_a, en_b;

    dice_counter u_die_a (.clk(clk), .rst(rst), .en(en_a), .value(die_a));
    dice_counter u_die_b (.clk(clk), .rst(rst), .en(en_b), .value(die_b));

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        win_next   = win;
        cnt_next   = hold_cnt;
        en_a       = 1'b0;
        en_b       = 1'b0;
        case (state)
            IDLE: if (roll_a) begin
                en_a       = 1'b1;
                next_state = ROLL_A;
            end
            ROLL_A: if (roll_a) en_a = 1'b1;
                    else        next_state = WAIT_B;
            WAIT_B: if (roll_b) begin
                en_b       = 1'b1;
                next_state = ROLL_B;
            end
            ROLL_B: if (roll_b) en_b = 1'b1;
                    else        next_state = JUDGE;
            JUDGE: begin
                cnt_next   = '0;
                next_state = SHOW;
                if (die_a > die_b)
                    win_next = WIN_A;
                else if (die_b > die_a)
                    win_next = WIN_B;
                else begin
`ifdef DICE_TIE_REROLL_EN
                    win_next   = WIN_NONE;
                    next_state = IDLE;
`else
                    win_next   = WIN_DRAW;
`endif
                end
            end
            SHOW: if (hold_cnt == HOLD_LAST) begin
                win_next   = WIN_NONE;
                cnt_next   = '0;
                next_state = IDLE;
            end else begin
                cnt_next   = hold_cnt + 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // busy decodes the next state so it lines up with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win      <= WIN_NONE;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            win      <= win_next;
            busy     <= (next_state != IDLE);
            hold_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_dice_judge.sv
// Self-checking bench for dice_judge: table-driven rounds plus hand-written corner sequences.
module tb_dice_judge;
    import dice_pkg::*;

    localparam int HOLD = 20;
    localparam int HW   = 5;
`ifdef DICE_TIE_REROLL_EN
    localparam logic [2:0] TIE_CODE = WIN_NONE;
`else
    localparam logic [2:0] TIE_CODE = WIN_DRAW;
`endif

    logic       clk = 1'b0;
    logic       rst, roll_a, roll_b;
    logic [2:0] die_a, die_b, win;
    logic       busy;

    always #5 clk = ~clk;

    dice_judge #(.HOLD_CYCLES(HOLD), .HW(HW)) dut (
        .clk(clk), .rst(rst), .roll_a(roll_a), .roll_b(roll_b),
        .die_a(die_a), .die_b(die_b), .win(win), .busy(busy)
    );

    typedef struct {
        int         a_cyc;
        int         b_cyc;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
        logic [2:0] exp_win;
    } vec_t;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] w;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        roll_a = 1'b0;
        roll_b = 1'b0;
        repeat (2) @(negedge clk);
        check("reset die_a", die_a, 1);
        check("reset die_b", die_b, 1);
        check("reset win", win, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the FSM in WAIT_B.
    task automatic a_phase(input int n);
        roll_a = 1'b1;
        repeat (n) @(negedge clk);
        roll_a = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the FSM in ROLL_B with roll_b low; next edge enters JUDGE.
    task automatic b_phase(input int n);
        roll_b = 1'b1;
        repeat (n) @(negedge clk);
        roll_b = 1'b0;
    endtask

    task automatic judge_check(input string tag);
        exp_t e;
        int   n;
        e = sb.pop_front();
        @(negedge clk);
        check({tag, " win@judge"}, win, 0);
        check({tag, " busy@judge"}, busy, 1);
        @(negedge clk);
        check({tag, " win"}, win, e.w);
        check({tag, " die_a"}, die_a, e.a);
        check({tag, " die_b"}, die_b, e.b);
        if (e.w == WIN_NONE) begin
            check({tag, " busy after tie"}, busy, 0);
        end else begin
            n = 0;
            while (win != WIN_NONE && n < HOLD + 10) begin
                n++;
                @(negedge clk);
            end
            check({tag, " hold cycles"}, n, HOLD);
            check({tag, " busy after show"}, busy, 0);
            check({tag, " die_a after show"}, die_a, e.a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3, 1, 3'd4, 3'd2, WIN_A};
        vecs[1] = '{8, 5, 3'd3, 3'd6, WIN_B};
        vecs[2] = '{4, 4, 3'd5, 3'd5, TIE_CODE};
        vecs[3] = '{6, 1, 3'd1, 3'd2, WIN_B};
        vecs[4] = '{5, 10, 3'd6, 3'd5, WIN_A};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            a_phase(vecs[i].a_cyc);
            b_phase(vecs[i].b_cyc);
            sb.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_win});
            judge_check($sformatf("vec%0d", i));
        end

        // Asynchronous reset while a win code is on display.
        do_reset();
        a_phase(3);
        b_phase(1);
        repeat (2) @(negedge clk);
        repeat (5) @(negedge clk);
        check("pre-reset win", win, WIN_A);
        #2 rst = 1'b1;
        #1;
        check("async rst win", win, 0);
        check("async rst busy", busy, 0);
        check("async rst die_a", die_a, 1);
        check("async rst die_b", die_b, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Off-turn buttons are ignored.
        do_reset();
        roll_b = 1'b1;
        repeat (3) @(negedge clk);
        check("idle roll_b die_b", die_b, 1);
        check("idle roll_b busy", busy, 0);
        roll_a = 1'b1;
        repeat (2) @(negedge clk);
        check("roll_a with roll_b die_a", die_a, 3);
        check("roll_a with roll_b die_b", die_b, 1);
        roll_a = 1'b0;
        roll_b = 1'b0;
        @(negedge clk);
        roll_a = 1'b1;
        repeat (3) @(negedge clk);
        check("wait_b roll_a die_a", die_a, 3);
        check("wait_b roll_a busy", busy, 1);
        check("wait_b roll_a win", win, 0);
        roll_a = 1'b0;
        b_phase(1);
        sb.push_back('{3'd3, 3'd2, WIN_A});
        judge_check("offturn");

        // roll_a held through JUDGE/SHOW starts a new round right after IDLE.
        do_reset();
        a_phase(2);
        roll_b = 1'b1;
        @(negedge clk);
        roll_b = 1'b0;
        roll_a = 1'b1;
        sb.push_back('{3'd3, 3'd2, WIN_A});
        judge_check("held");
        @(negedge clk);
        check("held new round die_a", die_a, 4);
        check("held new round busy", busy, 1);
        check("held new round win", win, 0);
        @(negedge clk);
        check("held new round die_a+1", die_a, 5);
        check("held new round win+1", win, 0);
        roll_a = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
